// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master and the companion slave model:
// controller states and the four clock modes encoded as {cpol, cpha}.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LEAD  = 3'd1,
        XFER  = 3'd2,
        TRAIL = 3'd3,
        DONE  = 3'd4
    } spi_state_t;

    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

endpackage

// File: rtl/spi_clk_div.sv
// Half-period tick generator: pulses tick on the last cycle of every
// (div+1)-cycle window while enabled; the count restarts whenever disabled.
module spi_clk_div #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [DIV_W-1:0] div,
    input  logic             en,
    output logic             tick
);

    logic [DIV_W-1:0] div_reg;
    logic [DIV_W-1:0] cnt_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_reg <= '0;
            cnt_reg <= '0;
        end else begin
            if (load) begin
                div_reg <= div;
            end
            if (!en || (cnt_reg == div_reg)) begin
                cnt_reg <= '0;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign tick = en && (cnt_reg == div_reg);

endmodule

// File: rtl/spi_master_multi.sv
// Parametrised SPI master: generic word width, all CPOL/CPHA modes, runtime
// bit order, programmable SCK divider and one-hot active-low slave selects.
module spi_master_multi
    import spi_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int NUM_SS = 4,
    parameter int DIV_W  = 8,
    parameter int SS_W   = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              lsb_first,
    input  logic [DIV_W-1:0]  clk_div,
    input  logic [SS_W-1:0]   ss_sel,
    input  logic [DATA_W-1:0] tx_data,
    output logic [DATA_W-1:0] rx_data,
    output logic              busy,
    output logic              done,
    output logic              sck,
    output logic              mosi,
    input  logic              miso,
    output logic [NUM_SS-1:0] ss_n
);

    localparam int HALVES = 2 * DATA_W;
    localparam int HC_W   = $clog2(HALVES) + 1;
    localparam logic [HC_W-1:0] LAST_HALF = HC_W'(HALVES - 1);

    spi_state_t state_reg, state_next;

    logic [DATA_W-1:0] tx_sh_reg, rx_sh_reg, rx_reg;
    logic              cpol_reg, cpha_reg, lsb_reg, sck_reg, mosi_reg;
    logic [SS_W-1:0]   sel_reg;
    logic [HC_W-1:0]   half_reg;
    logic [HC_W-1:0]   edge_idx;
    logic              tick, div_en, start_go;
    logic              edge_ev, lead_edge, sample_ev, shift_ev;
    logic [NUM_SS-1:0] sel_mask;

    assign start_go = (state_reg == IDLE) && start;
    assign div_en   = (state_reg == LEAD) || (state_reg == XFER) || (state_reg == TRAIL);

    spi_clk_div #(.DIV_W(DIV_W)) u_clk_div (
        .clk  (clk),
        .rst  (rst),
        .load (start_go),
        .div  (clk_div),
        .en   (div_en),
        .tick (tick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = LEAD;
            LEAD:    if (tick) state_next = XFER;
            XFER:    if (tick && (half_reg == LAST_HALF)) state_next = TRAIL;
            TRAIL:   if (tick) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // SCK edges: the end of LEAD enters half 0, each XFER tick but the last
    // enters the next half. Even halves begin with a leading edge.
    always_comb begin
        edge_ev  = 1'b0;
        edge_idx = '0;
        if ((state_reg == LEAD) && tick) begin
            edge_ev = 1'b1;
        end else if ((state_reg == XFER) && tick && (half_reg != LAST_HALF)) begin
            edge_ev  = 1'b1;
            edge_idx = half_reg + 1'b1;
        end
        lead_edge = ~edge_idx[0];
        sample_ev = edge_ev && (lead_edge ^ cpha_reg);
        shift_ev  = edge_ev && !sample_ev && !(!cpha_reg && (edge_idx == LAST_HALF));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_sh_reg <= '0;
            rx_sh_reg <= '0;
            rx_reg    <= '0;
            cpol_reg  <= 1'b0;
            cpha_reg  <= 1'b0;
            lsb_reg   <= 1'b0;
            sel_reg   <= '0;
            half_reg  <= '0;
            sck_reg   <= 1'b0;
            mosi_reg  <= 1'b0;
        end else begin
            if ((state_reg == IDLE) || (state_reg == DONE)) begin
                sck_reg <= cpol;
            end else if (edge_ev) begin
                sck_reg <= ~sck_reg;
            end else if (state_reg == TRAIL) begin
                sck_reg <= cpol_reg;
            end

            if (start_go) begin
                cpol_reg  <= cpol;
                cpha_reg  <= cpha;
                lsb_reg   <= lsb_first;
                sel_reg   <= ss_sel;
                half_reg  <= '0;
                rx_sh_reg <= '0;
                // CPHA=0 must show the first bit before the first leading edge
                if (cpha) begin
                    tx_sh_reg <= tx_data;
                    mosi_reg  <= 1'b0;
                end else begin
                    mosi_reg  <= lsb_first ? tx_data[0] : tx_data[DATA_W-1];
                    tx_sh_reg <= lsb_first ? (tx_data >> 1) : (tx_data << 1);
                end
            end else begin
                if ((state_reg == XFER) && tick) begin
                    half_reg <= half_reg + 1'b1;
                end
                if (shift_ev) begin
                    mosi_reg  <= lsb_reg ? tx_sh_reg[0] : tx_sh_reg[DATA_W-1];
                    tx_sh_reg <= lsb_reg ? (tx_sh_reg >> 1) : (tx_sh_reg << 1);
                end
                if (sample_ev) begin
                    rx_sh_reg <= lsb_reg ? {miso, rx_sh_reg[DATA_W-1:1]}
                                         : {rx_sh_reg[DATA_W-2:0], miso};
                end
                if ((state_reg == TRAIL) && tick) begin
                    rx_reg <= rx_sh_reg;
                end
                if (state_reg == DONE) begin
                    mosi_reg <= 1'b0;
                end
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_SS; gi++) begin : g_sel
            assign sel_mask[gi] = (sel_reg == SS_W'(gi));
        end
    endgenerate

    assign ss_n    = div_en ? ~sel_mask : '1;
    assign busy    = (state_reg != IDLE);
    assign done    = (state_reg == DONE);
    assign sck     = sck_reg;
    assign mosi    = mosi_reg;
    assign rx_data = rx_reg;

endmodule

// File: tb/tb_spi_master_multi.sv
// Randomised and directed bench for spi_master_multi: a transfer-level model
// predicts every output cycle by cycle, plus literal expectations per scenario.
module tb_spi_master_multi;
    import spi_pkg::*;

    localparam int W   = 8;
    localparam int NSS = 5;
    localparam int SSW = 3;
    localparam logic [NSS-1:0] SS_IDLE = '1;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0, cpol = 1'b0, cpha = 1'b0, lsb_first = 1'b0;
    logic [7:0]     clk_div = '0;
    logic [SSW-1:0] ss_sel = '0;
    logic [W-1:0]   tx_data = '0;
    logic [W-1:0]   rx_data;
    logic           busy, done, sck, mosi, miso;
    logic [NSS-1:0] ss_n;

    logic [W-1:0]   slave_word = '0;
    bit             loop_en = 1'b0;
    logic           slave_bit;

    logic           start16 = 1'b0;
    logic [1:0]     ss_sel16 = '0;
    logic [15:0]    tx16 = '0;
    logic [15:0]    rx16;
    logic           busy16, done16, sck16, mosi16;
    logic [3:0]     ss_n16;

    always #5 clk = ~clk;

    spi_master_multi #(.DATA_W(W), .NUM_SS(NSS), .DIV_W(8)) u_dut (
        .clk(clk), .rst(rst), .start(start), .cpol(cpol), .cpha(cpha),
        .lsb_first(lsb_first), .clk_div(clk_div), .ss_sel(ss_sel), .tx_data(tx_data),
        .rx_data(rx_data), .busy(busy), .done(done), .sck(sck), .mosi(mosi),
        .miso(miso), .ss_n(ss_n)
    );

    spi_master_multi #(.DATA_W(16), .NUM_SS(4), .DIV_W(8)) u_dut16 (
        .clk(clk), .rst(rst), .start(start16), .cpol(cpol), .cpha(cpha),
        .lsb_first(lsb_first), .clk_div(clk_div), .ss_sel(ss_sel16), .tx_data(tx16),
        .rx_data(rx16), .busy(busy16), .done(done16), .sck(sck16), .mosi(mosi16),
        .miso(mosi16), .ss_n(ss_n16)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic bit_of(input logic [W-1:0] w, input int b, input bit lsb);
        if (b < 0 || b >= W) return 1'b0;
        return lsb ? w[b] : w[W-1-b];
    endfunction

    // ---------------- transfer-level model ----------------
    int           cyc = 0;
    bit           m_active = 1'b0;
    int           m_t0 = 0, m_H = 1, m_L = 1, m_sel = 0;
    bit           m_cpol = 1'b0, m_cpha = 1'b0, m_lsb = 1'b0;
    logic [W-1:0] m_tx = '0, m_slave = '0, m_rx_new = '0, m_rx_exp = '0;
    bit           cpol_seen = 1'b0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_active  = 1'b0;
            m_rx_exp  = '0;
            cpol_seen = 1'b0;
        end else begin
            cyc++;
            if (m_active) begin
                if (cyc - m_t0 + 1 == m_L) m_rx_exp = m_rx_new;
                else if (cyc - m_t0 + 1 > m_L) m_active = 1'b0;
            end else if (start) begin
                m_active = 1'b1;
                m_t0     = cyc;
                m_H      = int'(clk_div) + 1;
                m_L      = (2 * W + 2) * m_H + 1;
                m_cpol   = cpol;
                m_cpha   = cpha;
                m_lsb    = lsb_first;
                m_sel    = int'(ss_sel);
                m_tx     = tx_data;
                m_slave  = slave_word;
                m_rx_new = loop_en ? tx_data : slave_word;
            end
            cpol_seen = cpol;
        end
    end

    int           samp_cnt = 0;
    int           mosi_n = 0;
    logic [W-1:0] mosi_log = '0;
    int           c_t, c_k;
    logic [NSS-1:0] c_ss;
    logic         c_sck;
    bit           c_in_xfer;

    assign slave_bit = bit_of(m_slave, samp_cnt, m_lsb);
    assign miso = loop_en ? mosi : slave_bit;

    always @(negedge clk) begin
        if (!rst) begin
            samp_cnt = 0;
            chk("rst_sck", sck, 1'b0);
            chk("rst_mosi", mosi, 1'b0);
            chk("rst_ss_n", ss_n, SS_IDLE);
            chk("rst_busy", busy, 1'b0);
            chk("rst_done", done, 1'b0);
            chk("rst_rx", rx_data, '0);
        end else if (m_active) begin
            c_t = cyc - m_t0 + 1;
            if (c_t == 1) begin
                samp_cnt = 0;
                mosi_n   = 0;
            end
            c_ss = SS_IDLE;
            if (c_t < m_L && m_sel < NSS) c_ss[m_sel] = 1'b0;
            c_in_xfer = (c_t > m_H) && (c_t <= m_H + 2 * W * m_H);
            c_k = c_in_xfer ? (c_t - m_H - 1) / m_H : 0;
            c_sck = c_in_xfer ? (m_cpol ^ (c_k % 2 == 0)) : m_cpol;
            chk("busy", busy, 1'b1);
            chk("done", done, c_t == m_L);
            chk("ss_n", ss_n, c_ss);
            chk("sck", sck, c_sck);
            chk("rx_data", rx_data, m_rx_exp);
            if (c_in_xfer && ((c_t - m_H - 1) % m_H == 0) && ((c_k % 2) == int'(m_cpha))) begin
                chk("mosi_bit", mosi, bit_of(m_tx, c_k / 2, m_lsb));
                if (mosi_n < W) mosi_log[mosi_n] = mosi;
                mosi_n++;
                samp_cnt = c_k / 2 + 1;
            end
        end else begin
            chk("idle_busy", busy, 1'b0);
            chk("idle_done", done, 1'b0);
            chk("idle_ss_n", ss_n, SS_IDLE);
            chk("idle_sck", sck, cpol_seen);
            chk("idle_rx", rx_data, m_rx_exp);
        end
    end

    // ---------------- cumulative observation counters ----------------
    int busy_total = 0, done_total = 0, tgl_total = 0;
    logic busy_prev = 1'b0, sck_prev = 1'b0;

    always @(negedge clk) begin
        if (busy && busy_prev && (sck != sck_prev)) tgl_total++;
        if (busy) busy_total++;
        if (done) done_total++;
        busy_prev = busy;
        sck_prev  = sck;
    end

    // ---------------- stimulus ----------------
    int             r_done_at, r_busy, r_tgl, r_dones;
    logic [NSS-1:0] r_ss_mid;

    task automatic do_xfer(input bit cp, input bit ch, input bit lf, input int dv,
                           input int sel, input logic [W-1:0] tx, input logic [W-1:0] sw,
                           input bit lp, input bit poke);
        int n, b0, t0, d0;
        @(posedge clk); #1;
        cpol = cp; cpha = ch; lsb_first = lf; clk_div = 8'(dv);
        ss_sel = SSW'(sel); tx_data = tx; slave_word = sw; loop_en = lp;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        b0 = busy_total; t0 = tgl_total; d0 = done_total;
        n = 0; r_done_at = -1; r_ss_mid = SS_IDLE;
        while (n < 400 && !(r_done_at > 0 && n > r_done_at + 1)) begin
            @(negedge clk);
            n++;
            if (n == 2) r_ss_mid = ss_n;
            if (poke && n == 6) begin start = 1'b1; tx_data = 8'hFF; end
            if (poke && n == 9) start = 1'b0;
            if (done && r_done_at < 0) r_done_at = n;
        end
        @(posedge clk); #1;
        r_busy  = busy_total - b0;
        r_tgl   = tgl_total - t0;
        r_dones = done_total - d0;
        chk("done_seen", r_done_at > 0, 1'b1);
        $display("xfer mode=%0d%0d lsb=%0d div=%0d sel=%0d tx=%h loop=%0d rx=%h done_at=%0d busy=%0d",
                 cp, ch, lf, dv, sel, tx, lp, rx_data, r_done_at, r_busy);
    endtask

    int n16, tgl16, bcnt16, done16_at;
    logic pb16, ps16;
    logic [3:0] ss16_mid;

    initial begin
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_ss_n", ss_n, SS_IDLE);
        chk("reset_rx", rx_data, '0);
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);

        // mode 0, fastest clock, loopback
        do_xfer(1'b0, 1'b0, 1'b0, 0, 0, 8'hA5, 8'h00, 1'b1, 1'b0);
        chk("m0_rx", rx_data, 8'hA5);
        chk("m0_done_at", r_done_at, 19);
        chk("m0_ss_n", r_ss_mid, 5'b11110);
        chk("m0_sck_edges", r_tgl, 16);
        chk("m0_dones", r_dones, 1);

        // mode 3, divider 3, LSB first, slave drives 0x81
        do_xfer(MODE3[1], MODE3[0], 1'b1, 3, 2, 8'h3C, 8'h81, 1'b0, 1'b0);
        chk("m3_rx", rx_data, 8'h81);
        chk("m3_busy", r_busy, 73);
        chk("m3_mosi_seq", {mosi_log[0], mosi_log[1], mosi_log[2], mosi_log[3],
                            mosi_log[4], mosi_log[5], mosi_log[6], mosi_log[7]}, 8'b0011_1100);
        chk("m3_ss_n", r_ss_mid, 5'b11011);

        // start re-asserted mid-transfer is ignored
        do_xfer(1'b0, 1'b0, 1'b0, 0, 1, 8'h42, 8'h00, 1'b1, 1'b1);
        chk("poke_rx", rx_data, 8'h42);
        chk("poke_dones", r_dones, 1);
        repeat (4) @(negedge clk);
        chk("poke_no_requeue", busy, 1'b0);

        // reset asserted while bit 4 is on the wire
        @(posedge clk); #1;
        cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0; clk_div = 8'd1; ss_sel = 3'd0;
        tx_data = 8'h33; loop_en = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (19) @(negedge clk);
        chk("abort_busy_before", busy, 1'b1);
        #2 rst = 1'b0;
        #1;
        chk("abort_ss_n", ss_n, SS_IDLE);
        chk("abort_sck", sck, 1'b0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_rx", rx_data, '0);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        do_xfer(1'b0, 1'b0, 1'b0, 0, 0, 8'h5A, 8'h00, 1'b1, 1'b0);
        chk("after_abort_rx", rx_data, 8'h5A);

        // out-of-range select: no line asserted, transfer still completes
        do_xfer(1'b1, 1'b0, 1'b0, 1, 5, 8'h96, 8'h00, 1'b1, 1'b0);
        chk("nosel_ss_n", r_ss_mid, SS_IDLE);
        chk("nosel_dones", r_dones, 1);
        chk("nosel_sck_edges", r_tgl, 16);
        chk("nosel_rx", rx_data, 8'h96);

        // randomised transfers against the model
        for (int i = 0; i < 24; i++) begin
            int dv;
            dv = int'($urandom_range(0, 3));
            do_xfer(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    dv, int'($urandom_range(0, 7)), 8'($urandom), 8'($urandom),
                    1'($urandom_range(0, 1)), 1'b0);
            chk("rand_done_at", r_done_at, (2 * W + 2) * (dv + 1) + 1);
            chk("rand_dones", r_dones, 1);
        end

        // 16-bit instance, mode 1, loopback
        @(posedge clk); #1;
        {cpol, cpha} = MODE1; lsb_first = 1'b0; clk_div = 8'd0;
        tx16 = 16'hBEEF; ss_sel16 = 2'd2; start16 = 1'b1;
        @(posedge clk); #1;
        start16 = 1'b0;
        n16 = 0; tgl16 = 0; bcnt16 = 0; done16_at = -1; pb16 = 1'b0; ps16 = sck16; ss16_mid = '1;
        while (n16 < 200 && !(done16_at > 0 && n16 > done16_at + 1)) begin
            @(negedge clk);
            n16++;
            if (busy16 && pb16 && (sck16 != ps16)) tgl16++;
            if (busy16) bcnt16++;
            if (done16 && done16_at < 0) done16_at = n16;
            if (n16 == 2) ss16_mid = ss_n16;
            pb16 = busy16;
            ps16 = sck16;
        end
        $display("xfer16 mode=01 tx=%h rx=%h done_at=%0d busy=%0d", tx16, rx16, done16_at, bcnt16);
        chk("w16_rx", rx16, 16'hBEEF);
        chk("w16_sck_edges", tgl16, 32);
        chk("w16_busy", bcnt16, 35);
        chk("w16_done_at", done16_at, 35);
        chk("w16_ss_n", ss16_mid, 4'b1011);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
